// File: rtl/lsu_sequencer.sv
// lsu_sequencer: multi-cycle load/store sequencer between the core and a
// word-wide data memory with a req/gnt/rvalid handshake.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            core request handshake (ready = IDLE)
//   req_write, req_addr, req_wdata core access description
//   store_type, load_type          access size/extension codes
//   stall                          hold core pipeline until completion
//   rsp_valid/rsp_rdata/rsp_err/err_code  one-cycle completion report
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata  memory request side
//   mem_gnt/mem_rvalid/mem_rdata   memory response side
//
// state | meaning
// IDLE  | waiting for a core request
// REQ   | mem_req asserted, waiting for mem_gnt
// WAIT  | load granted, waiting for mem_rvalid
// RESP  | rsp_valid pulse, back to IDLE next cycle
module lsu_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  store_type,
  input  logic [2:0]  load_type,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  lt_q, lt_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        illegal, misal;
  logic [3:0]  be_acc;
  logic [31:0] wd_acc;

  function automatic logic [31:0] extract(input logic [2:0] lt, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [31:0] b, h;
    b = w >> {off, 3'b000};
    h = w >> {off[1], 4'b0000};
    case (lt)
      3'd0:    extract = w;
      3'd1:    extract = {{16{h[15]}}, h[15:0]};
      3'd2:    extract = {16'h0000, h[15:0]};
      3'd3:    extract = {{24{b[7]}}, b[7:0]};
      3'd4:    extract = {24'h000000, b[7:0]};
      default: extract = 32'h0;
    endcase
  endfunction

  // Request classification; illegal wins over misaligned in the FSM.
  always_comb begin
    illegal = req_write ? (store_type == 2'b11) : (load_type > 3'd4);
    if (req_write)
      misal = ((store_type == 2'b00) && (req_addr[1:0] != 2'b00)) ||
              ((store_type == 2'b01) && req_addr[0]);
    else
      misal = ((load_type == 3'd0) && (req_addr[1:0] != 2'b00)) ||
              (((load_type == 3'd1) || (load_type == 3'd2)) && req_addr[0]);
    case (store_type)
      2'b00:   begin be_acc = 4'b1111; wd_acc = req_wdata; end
      2'b01:   begin
                 be_acc = req_addr[1] ? 4'b1100 : 4'b0011;
                 wd_acc = {2{req_wdata[15:0]}};
               end
      default: begin be_acc = 4'b0001 << req_addr[1:0]; wd_acc = {4{req_wdata[7:0]}}; end
    endcase
    if (!req_write) be_acc = 4'b1111;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    off_d       = off_q;
    lt_d        = lt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    err_code_d  = 2'b00;
    case (state_q)
      IDLE: if (req_valid) begin
        write_d = req_write;
        off_d   = req_addr[1:0];
        lt_d    = load_type;
        if (illegal || misal) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          err_code_d  = illegal ? 2'b11 : 2'b01;
        end else begin
          state_d     = REQ;
          cnt_d       = 8'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = req_write;
          mem_addr_d  = {req_addr[31:2], 2'b00};
          mem_be_d    = be_acc;
          mem_wdata_d = wd_acc;
        end
      end
      REQ, WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (state_q == REQ && mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          if (write_q) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
          end else if (mem_rvalid) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = extract(lt_q, off_q, mem_rdata);
          end else begin
            state_d = WAIT;
          end
        end else if (state_q == WAIT && mem_rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = extract(lt_q, off_q, mem_rdata);
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          err_code_d  = 2'b10;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'b0000;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      write_q     <= 1'b0;
      off_q       <= 2'b00;
      lt_q        <= 3'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      off_q       <= off_d;
      lt_q        <= lt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign stall     = (state_q != RESP) && ((state_q != IDLE) || req_valid);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign err_code  = err_code_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
